// File: rtl/pipe_mux_n_pkg.sv
// rtl/pipe_mux_n_pkg.sv - shared datapath types for the pipelined N-way selector
package pipe_mux_n_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Number of beats held by the output stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_mux_n_sel_n.sv
// rtl/pipe_mux_n_sel_n.sv - combinational N-way select with out-of-range flag
module sel_n
  import pipe_mux_n_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int N     = 3,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   sel_data,
  output logic               err
);

  always_comb begin
    sel_data = '0;
    // Widened compare stays correct when N is a power of two.
    err      = ({1'b0, sel} >= (SEL_W + 1)'(N));
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// rtl/pipe_mux_n.sv - N-way selector with registered valid/ready output and skid buffer
module pipe_mux_n
  import pipe_mux_n_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int N     = 3,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  state_t           state;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             accept;
  logic             deliver;

  sel_n #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .data     (in_data),
    .sel      (in_sel),
    .sel_data (sel_data),
    .err      (sel_err)
  );

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // in_ready is registered and tracks "skid empty", so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= sel_data;
            out_err   <= sel_err;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            out_data <= sel_data;
            out_err  <= sel_err;
          end else if (accept) begin
            skid_data <= sel_data;
            skid_err  <= sel_err;
            in_ready  <= 1'b0;
            state     <= ST_TWO;
          end else if (deliver) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (deliver) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb/tb_pipe_mux_n.sv - directed and randomised self-checking bench for pipe_mux_n
module tb_pipe_mux_n;
  import pipe_mux_n_pkg::*;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;

  int errors = 0;
  int checks = 0;

  pipe_mux_n #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  beat_t       exp_q[$];
  beat_t       exp_b;
  logic [31:0] ch [3];
  logic        stall;
  logic [31:0] held_data;
  logic        held_err;
  int          beats;
  int          cycles;
  logic        acc;
  logic        del;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = '0; out_ready = 1'b1;
    in_data = {32'h33, 32'h22, 32'h11};
    #1;

    // Reset held for two cycles with in_valid asserted.
    tick();
    check("rst1_out_valid", out_valid, 0);
    tick();
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_data", out_data, 0);
    check("rst2_out_err", out_err, 0);
    check("rst2_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Streaming: one beat per cycle, one cycle latency.
    in_valid = 1'b1; in_sel = 2'd0;
    tick();
    check("stream0_valid", out_valid, 1);
    check("stream0_data", out_data, 32'h11);
    in_sel = 2'd1;
    tick();
    check("stream1_data", out_data, 32'h22);
    check("stream1_in_ready", in_ready, 1);
    in_sel = 2'd2;
    tick();
    check("stream2_data", out_data, 32'h33);
    check("stream2_err", out_err, 0);
    in_valid = 1'b0;
    tick();
    check("stream_drained", out_valid, 0);

    // Backpressure: two beats held, third refused.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    tick();
    check("bp0_data", out_data, 32'h11);
    check("bp0_in_ready", in_ready, 1);
    in_sel = 2'd1;
    tick();
    check("bp1_in_ready", in_ready, 0);
    check("bp1_data", out_data, 32'h11);
    in_sel = 2'd2;
    tick();
    check("bp2_in_ready", in_ready, 0);
    check("bp2_data_stable", out_data, 32'h11);
    check("bp2_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_rel1_data", out_data, 32'h22);
    check("bp_rel1_in_ready", in_ready, 1);
    tick();
    check("bp_rel2_data", out_data, 32'h33);
    check("bp_rel2_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 0);

    // Out-of-range select.
    in_valid = 1'b1; in_sel = 2'd3;
    tick();
    check("bad_sel_data", out_data, 0);
    check("bad_sel_err", out_err, 1);
    in_sel = 2'd1;
    tick();
    check("after_bad_data", out_data, 32'h22);
    check("after_bad_err", out_err, 0);
    in_valid = 1'b0;
    tick();
    check("bad_drained", out_valid, 0);

    // Reset while two beats are held.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
    tick();
    in_sel = 2'd0;
    tick();
    check("mid_two_in_ready", in_ready, 0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_ghost", out_valid, 0);
    end

    // Random valid/ready with a scoreboard.
    stall = 1'b0; held_data = '0; held_err = 1'b0;
    beats = 0; cycles = 0;
    while (beats < 10000 && cycles < 60000) begin
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_data);
        check("stall_err", out_err, held_err);
      end
      for (int k = 0; k < 3; k++) ch[k] = $urandom;
      in_data   = {ch[2], ch[1], ch[0]};
      in_sel    = SEL_W'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      acc = in_valid & in_ready;
      del = out_valid & out_ready;
      if (del) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_beat", 1, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check("rand_data", out_data, exp_b.data);
          check("rand_err", out_err, exp_b.err);
          beats++;
        end
      end
      if (acc) begin
        exp_b.err  = (in_sel >= 2'd3);
        exp_b.data = (in_sel < 2'd3) ? ch[in_sel] : 32'h0;
        exp_q.push_back(exp_b);
      end
      stall     = out_valid & ~out_ready;
      held_data = out_data;
      held_err  = out_err;
      tick();
      cycles++;
    end
    check("rand_beat_budget", (beats >= 10000), 1);

    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_spurious_beat", 1, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check("drain_data", out_data, exp_b.data);
          check("drain_err", out_err, exp_b.err);
        end
      end
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
